imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Writer for the CPU instruction memory: a framed 32-bit word stream is written into instr_mem from word 0 upward.
- Holds the core in reset while loading.
- Releases the core only after a valid header, payload and checksum.
- Replaces hierarchical testbench preloading with a synthesizable load path. Sits between a host/debug stream source and the instruction-memory write port.

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 256: instruction-memory capacity in words, must be <= 2**ADDR_W.
- MAGIC, 16'hB007: required header upper half.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- s_valid  input  1  stream word valid
- s_data  input  32  stream word
- s_ready  output  1  loader accepts a word this cycle
- restart  input  1  single-cycle pulse; re-arms the loader from RUN or ERROR
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_W  instruction-memory word address
- imem_wdata  output  32  instruction-memory write data
- cpu_reset  output  1  active-high reset to the CPU core
- done  output  1  load complete, CPU running
- error  output  1  load failed
- words_loaded  output  16  count of payload words written

Behaviour:
- Beat acceptance: a beat is accepted when s_valid and s_ready are both 1 on a rising clk. s_data is sampled only on accepted beats.
- Reset (reset=0, asynchronous): state=IDLE, cpu_reset=1, s_ready=0 while reset is held, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, words_loaded=0, count=0, checksum accumulator=0.
- Reset mid-load abandons the frame. Partially written memory contents are not cleared.
- IDLE:
  - s_ready=1.
  - Header beat is {MAGIC, count[15:0]}.
  - Upper half != MAGIC, or count > DEPTH -> ERROR.
  - count == 0 -> CHECK.
  - Otherwise -> LOAD. Latch count, clear accumulator and words_loaded.
- LOAD:
  - s_ready=1.
  - Each accepted beat causes, on the following cycle, imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=beat. imem_we is a one-cycle pulse per beat.
  - This is a registered write with 1-cycle latency; back-to-back beats give back-to-back writes.
  - Accumulator += beat, modulo 2**32. words_loaded increments with each accepted beat.
  - When the count-th beat is accepted -> CHECK.
- CHECK:
  - s_ready=1.
  - The next accepted beat is compared with the accumulator.
  - Equal -> RUN. Unequal -> ERROR.
  - The checksum beat is never written to memory.
- RUN:
  - s_ready=0, done=1, cpu_reset=0.
  - cpu_reset deasserts the cycle after the checksum beat is accepted. The final imem write has already occurred by that cycle.
- ERROR: s_ready=0, error=1, cpu_reset=1.
- restart:
  - In RUN or ERROR, restart=1 -> IDLE on the next edge. cpu_reset=1, done=0, error=0, words_loaded=0.
  - restart is ignored in IDLE, LOAD and CHECK.
- Stalls: s_valid=0 inserts stalls in any accepting state with no state change and no write.
- Address range: imem_addr never exceeds DEPTH-1 (guaranteed by the count check). count == DEPTH is legal and fills memory exactly.
- Outputs: all outputs are registered except s_ready, which is decoded from state. Outputs do not depend combinationally on s_valid.

Test Plan:
- Normal load: release reset; send 0xB0070002, 0x20030000, 0x2001000F, 0x4004000F back-to-back. Required: writes addr0=0x20030000 then addr1=0x2001000F on consecutive cycles; done=1, cpu_reset=0 one cycle after the last beat; words_loaded=2.
- Bad checksum: same frame with last word 0x4004000E. Required: both writes occur; error=1, cpu_reset stays 1, s_ready=0. A restart pulse returns to IDLE with error=0.
- Bad header and oversize: header 0xBEEF0002 -> ERROR with no imem_we. Header 0xB0070101 with DEPTH=256 -> ERROR.
- Zero-length and full-depth: 0xB0070000 then 0x00000000 -> RUN, no writes. DEPTH-word frame -> last write at addr 255, RUN.
- Stalls and reset: drop s_valid for 3 cycles between payload beats, so writes follow accepted beats only. Assert reset low mid-LOAD: all outputs return to reset values asynchronously, then a fresh frame loads correctly.

Source files
------------

// File: rtl/imem_program_loader.sv
// Loads a framed word stream (header, payload, checksum) into instruction memory
// from word 0 upward, holding the CPU in reset until the frame validates.
module imem_program_loader #(
    parameter int          ADDR_W = 8,
    parameter int          DEPTH  = 256,
    parameter logic [15:0] MAGIC  = 16'hB007
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded,
    output logic [2:0]        fsm_state
);

    // Stream handshake: a beat transfers on a rising clk edge when s_valid and
    // s_ready are both 1; s_data is only looked at on such beats. s_ready is
    // a pure decode of state (and reset), never of s_valid.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state;
    state_t      next_state;
    logic [15:0] count;
    logic [31:0] acc;
    logic        beat;
    logic        hdr_ok;
    logic        last_payload;

    assign hdr_ok       = (s_data[31:16] == MAGIC) && ({1'b0, s_data[15:0]} <= DEPTH_L);
    assign last_payload = (words_loaded + 16'd1) == count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (beat) begin
                    if (!hdr_ok)                    next_state = ST_ERROR;
                    else if (s_data[15:0] == 16'd0) next_state = ST_CHECK;
                    else                            next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat && last_payload) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (beat) next_state = (s_data == acc) ? ST_RUN : ST_ERROR;
            end
            ST_RUN, ST_ERROR: begin
                if (restart) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        fsm_state = state;
        if (state == ST_IDLE || state == ST_LOAD || state == ST_CHECK) begin
            s_ready = reset;
        end
        beat = s_valid && s_ready;
    end

    // Status flags follow next_state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            count        <= '0;
            acc          <= '0;
        end else begin
            imem_we   <= 1'b0;
            done      <= (next_state == ST_RUN);
            error     <= (next_state == ST_ERROR);
            cpu_reset <= (next_state != ST_RUN);
            case (state)
                ST_IDLE: begin
                    if (beat) begin
                        count        <= s_data[15:0];
                        acc          <= '0;
                        words_loaded <= '0;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_W-1:0];
                        imem_wdata   <= s_data;
                        acc          <= acc + s_data;
                        words_loaded <= words_loaded + 16'd1;
                    end
                end
                ST_RUN, ST_ERROR: begin
                    if (restart) words_loaded <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized and directed frames for imem_program_loader, checked against a
// frame-level reference model and a timestamped write scoreboard.
module tb_imem_program_loader;

    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 256;
    localparam logic [15:0] MAGIC  = 16'hB007;

    logic              clk;
    logic              reset;
    logic              s_valid;
    logic [31:0]       s_data;
    logic              s_ready;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;
    logic [2:0]        fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected write: {cycle, addr, data}
    logic [71:0] exp_q[$];
    logic [31:0] pl_q[$];

    imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'd0, imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [71:0] e;
                e = exp_q.pop_front();
                check("write_cycle", 64'(cyc), 64'(e[71:40]));
                check("write_addr", 64'(imem_addr), 64'(e[39:32]));
                check("write_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = $urandom;
        end
    endtask

    task automatic send_beat(input logic [31:0] w, input bit is_payload, input int idx);
        @(negedge clk);
        check("s_ready_before_beat", 64'(s_ready), 64'd1);
        if (s_ready !== 1'b1) begin
            s_valid = 1'b0;
            return;
        end
        s_valid = 1'b1;
        s_data  = w;
        if (is_payload) exp_q.push_back({32'(cyc + 1), 8'(idx), w});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    function automatic logic [31:0] sum_q();
        logic [31:0] s = 32'd0;
        foreach (pl_q[i]) s = s + pl_q[i];
        return s;
    endfunction

    // Reference model: header rules decide ERROR/LOAD; the checksum is the
    // modulo-2^32 sum of the payload words; payload word i lands at address i.
    task automatic run_frame(input string name, input logic [31:0] hdr, input logic [31:0] chk,
                             input int max_stall, input int fixed_stall);
        bit          hdr_ok;
        bit          exp_run;
        logic [31:0] sum;
        hdr_ok  = (hdr[31:16] == MAGIC) && (int'(hdr[15:0]) <= DEPTH);
        sum     = 32'd0;
        exp_run = 1'b0;
        send_beat(hdr, 1'b0, 0);
        if (hdr_ok) begin
            for (int i = 0; i < int'(hdr[15:0]); i++) begin
                idle(fixed_stall > 0 ? fixed_stall : $urandom_range(0, max_stall));
                send_beat(pl_q[i], 1'b1, i);
                sum = sum + pl_q[i];
            end
            idle($urandom_range(0, max_stall));
            send_beat(chk, 1'b0, 0);
            exp_run = (chk == sum);
        end
        @(negedge clk);
        check({name, "_done"}, 64'(done), 64'(exp_run));
        check({name, "_error"}, 64'(error), 64'(!exp_run));
        check({name, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_run));
        check({name, "_s_ready"}, 64'(s_ready), 64'd0);
        check({name, "_words_loaded"}, 64'(words_loaded), hdr_ok ? 64'(hdr[15:0]) : 64'd0);
        check({name, "_writes_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_restart(input string name);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check({name, "_rst_done"}, 64'(done), 64'd0);
        check({name, "_rst_error"}, 64'(error), 64'd0);
        check({name, "_rst_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check({name, "_rst_words"}, 64'(words_loaded), 64'd0);
        check({name, "_rst_s_ready"}, 64'(s_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check({name, "_s_ready"}, 64'(s_ready), 64'd0);
        check({name, "_imem_we"}, 64'(imem_we), 64'd0);
        check({name, "_imem_addr"}, 64'(imem_addr), 64'd0);
        check({name, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_error"}, 64'(error), 64'd0);
        check({name, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        logic [31:0] chk;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;
        restart = 1'b0;
        #23;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;

        // Known-good frame from the plan, back-to-back
        pl_q = '{32'h2003_0000, 32'h2001_000F};
        run_frame("normal", 32'hB007_0002, 32'h4004_000F, 0, 0);
        do_restart("normal");

        run_frame("bad_chk", 32'hB007_0002, 32'h4004_000E, 0, 0);
        do_restart("bad_chk");

        run_frame("bad_magic", 32'hBEEF_0002, 32'h0, 0, 0);
        do_restart("bad_magic");

        run_frame("oversize", 32'hB007_0101, 32'h0, 0, 0);
        do_restart("oversize");

        pl_q.delete();
        run_frame("zero_len", 32'hB007_0000, 32'h0000_0000, 0, 0);
        do_restart("zero_len");

        // restart pulse in IDLE must be ignored
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("idle_restart_s_ready", 64'(s_ready), 64'd1);
        check("idle_restart_error", 64'(error), 64'd0);

        // Three-cycle stalls before every payload beat
        pl_q.delete();
        repeat (3) pl_q.push_back($urandom);
        run_frame("stall", 32'hB007_0003, sum_q(), 0, 3);
        do_restart("stall");

        pl_q.delete();
        repeat (DEPTH) pl_q.push_back($urandom);
        run_frame("full_depth", {MAGIC, 16'(DEPTH)}, sum_q(), 0, 0);
        do_restart("full_depth");

        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, 12);
            pl_q.delete();
            repeat (len) pl_q.push_back($urandom);
            chk = sum_q();
            if ($urandom_range(0, 1) == 1) chk = chk ^ (32'd1 << $urandom_range(0, 31));
            run_frame($sformatf("rand%0d", f), {MAGIC, 16'(len)}, chk, 2, 0);
            do_restart($sformatf("rand%0d", f));
        end

        // Asynchronous reset mid-LOAD abandons the frame
        pl_q.delete();
        repeat (5) pl_q.push_back($urandom);
        send_beat(32'hB007_0005, 1'b0, 0);
        send_beat(pl_q[0], 1'b1, 0);
        send_beat(pl_q[1], 1'b1, 1);
        idle(1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid_load");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        pl_q.delete();
        repeat (4) pl_q.push_back($urandom);
        run_frame("after_reset", 32'hB007_0004, sum_q(), 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
